ucie_ctl_sb_tx_queued: RTL

//  Parametrised successor to the sideband TX top: queues up to DEPTH LP sideband messages.

---
 rtl/ucie_ctl_sb_tx_queued.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ucie_ctl_sb_tx_queued.sv
// Sideband TX with a message FIFO: each queued message is sent as a header phase and an
// optional data phase, in NC-bit beats on lp_cfg, paced by a PL credit counter.
module ucie_ctl_sb_tx_queued #(
  parameter  int NC      = 32,
  parameter  int DEPTH   = 4,
  parameter  int MAX_CRD = 4,
  localparam int CW      = $clog2(MAX_CRD + 1),
  localparam int AW      = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid_lp_sb,
  input  logic [4:0]    i_rdi_lp_sb_decode,
  input  logic          i_has_data,
  input  logic [31:0]   i_rdi_lp_adv_cap_value,
  output logic          o_pl_sb_busy,
  input  logic          i_rdi_pl_cfg_crd,
  output logic          o_rdi_lp_cfg_vld,
  output logic [NC-1:0] o_rdi_lp_cfg,
  output logic [CW-1:0] o_crd_cnt,
  output logic          o_crd_err,
  output logic [AW-1:0] o_fifo_cnt
);

  localparam int BEATS = 64 / NC;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_e;

  typedef struct packed {
    logic        has_data;
    logic [4:0]  decode;
    logic [31:0] value;
  } msg_t;

  msg_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] crd_q, crd_d;
  logic          err_q, err_d;
  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  msg_t          cur_q, cur_d;
  logic          vld_q, vld_d;
  logic [NC-1:0] cfg_q, cfg_d;

  logic          busy, push, pop, can_start, last_beat;
  msg_t          head, push_msg;
  logic [63:0]   phase;
  logic [5:0]    bit_off;

  assign busy      = (cnt_q == AW'(DEPTH));
  assign push      = i_valid_lp_sb & ~busy;
  assign push_msg  = '{has_data: i_has_data, decode: i_rdi_lp_sb_decode,
                       value: i_rdi_lp_adv_cap_value};
  assign head      = mem_q[rd_ptr_q];
  // Both occupancy and credit are the pre-edge values, so a same-cycle push or return never starts a packet.
  assign can_start = (cnt_q != '0) && (crd_q != '0);
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign phase     = (state_q == ST_HDR) ? {58'b0, cur_q.has_data, cur_q.decode}
                                         : {32'b0, cur_q.value};
  assign bit_off   = 6'(int'(beat_q) * NC);

  // Packet sequencer: header beats, optional data beats, then either chain the next packet or idle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    beat_d  = beat_q;
    cur_d   = cur_q;
    pop     = 1'b0;
    vld_d   = 1'b0;
    cfg_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = ST_HDR;
          beat_d  = '0;
        end
      end
      ST_HDR, ST_DATA: begin
        vld_d = 1'b1;
        cfg_d = phase[bit_off +: NC];
        if (!last_beat) begin
          beat_d = beat_q + 1'b1;
        end else if (state_q == ST_HDR && cur_q.has_data) begin
          state_d = ST_DATA;
          beat_d  = '0;
        end else if (can_start) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = ST_HDR;
          beat_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + AW'(push) - AW'(pop);
    crd_d    = crd_q;
    err_d    = err_q;
    case ({pop, i_rdi_pl_cfg_crd})
      2'b10: crd_d = crd_q - 1'b1;
      2'b01: begin
        if (crd_q == CW'(MAX_CRD)) err_d = 1'b1;
        else                       crd_d = crd_q + 1'b1;
      end
      default: crd_d = crd_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      crd_q    <= CW'(MAX_CRD);
      err_q    <= 1'b0;
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      cur_q    <= '0;
      vld_q    <= 1'b0;
      cfg_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      crd_q    <= crd_d;
      err_q    <= err_d;
      state_q  <= state_d;
      beat_q   <= beat_d;
      cur_q    <= cur_d;
      vld_q    <= vld_d;
      cfg_q    <= cfg_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_msg;
  end

  assign o_pl_sb_busy     = busy;
  assign o_rdi_lp_cfg_vld = vld_q;
  assign o_rdi_lp_cfg     = cfg_q;
  assign o_crd_cnt        = crd_q;
  assign o_crd_err        = err_q;
  assign o_fifo_cnt       = cnt_q;

endmodule
